// File: rtl/icb_arb2.sv
// -----------------------------------------------------------------------------
// icb_arb2 : two-master / one-slave ICB arbiter with response watchdog.
//
// Grants one command at a time, keeps the grant until the matching response
// completes and steers that response back to the owning master. If the slave
// does not answer within TO_CYC cycles of accepting the command, the arbiter
// answers the owner itself with err=1, rdata=0.
//
// Parameters
//   AW      address width
//   DW      data width (write mask is DW/8 bits)
//   TO_CYC  response timeout in cycles after command acceptance, 0 = off
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   m0_icb_cmd_* / rsp_*  master 0 (core) command and response channels
//   m1_icb_cmd_* / rsp_*  master 1 (debug/DMA) command and response channels
//   s_icb_cmd_* / rsp_*   shared slave command and response channels
//   timeout_o           one-cycle pulse when the watchdog fires
//
// Configuration macro
//   ICB_ARB_RR_EN  defined    : round-robin, pointer moves to the non-owner
//                               after every completed response
//                  undefined  : fixed priority, m1 wins ties
// -----------------------------------------------------------------------------
module icb_arb2 #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic            m0_icb_cmd_read,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,
  // master 1
  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic            m1_icb_cmd_read,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,
  // slave
  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic            s_icb_cmd_read,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata,
  // watchdog
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // The counter holds the number of RSP cycles already spent waiting; the
  // watchdog fires in the cycle that would bring that number to TO_CYC.
  localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

  state_e        state_q, state_d;
  logic          own_q, own_d;
  logic          to_q, to_d;        // watchdog error response is being held
  logic [CW-1:0] cnt_q, cnt_d;

  logic          any_valid_s;
  logic          sel_s;
  logic          cmd_own_s;
  logic          cmd_path_s;
  logic          cmd_hs_s;
  logic          wd_hit_s;
  logic          own_rsp_ready_s;
  logic          rsp_valid_s;
  logic          rsp_err_s;
  logic [DW-1:0] rsp_rdata_s;
  logic          rsp_done_s;

  assign any_valid_s = m0_icb_cmd_valid | m1_icb_cmd_valid;

`ifdef ICB_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign sel_s = (m0_icb_cmd_valid & m1_icb_cmd_valid) ? ptr_q : m1_icb_cmd_valid;
`else
  // m1 wins a tie; with no request m0 is nominally selected
  assign sel_s = m1_icb_cmd_valid;
`endif

  // Command routing: free choice in IDLE, locked to the owner in CMD
  assign cmd_own_s  = (state_q == ST_IDLE) ? sel_s : own_q;
  assign cmd_path_s = ((state_q == ST_IDLE) & any_valid_s) | (state_q == ST_CMD);

  // Command mux toward the slave; everything is zero when no command is routed
  always_comb begin
    s_icb_cmd_valid = 1'b0;
    s_icb_cmd_addr  = '0;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = '0;
    s_icb_cmd_wmask = '0;
    if (cmd_path_s) begin
      if (cmd_own_s) begin
        s_icb_cmd_valid = m1_icb_cmd_valid;
        s_icb_cmd_addr  = m1_icb_cmd_addr;
        s_icb_cmd_read  = m1_icb_cmd_read;
        s_icb_cmd_wdata = m1_icb_cmd_wdata;
        s_icb_cmd_wmask = m1_icb_cmd_wmask;
      end else begin
        s_icb_cmd_valid = m0_icb_cmd_valid;
        s_icb_cmd_addr  = m0_icb_cmd_addr;
        s_icb_cmd_read  = m0_icb_cmd_read;
        s_icb_cmd_wdata = m0_icb_cmd_wdata;
        s_icb_cmd_wmask = m0_icb_cmd_wmask;
      end
    end else begin
      s_icb_cmd_valid = 1'b0;
    end
  end

  // Only the selected/owning master sees the slave's ready, and only outside RSP
  always_comb begin
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    if (state_q != ST_RSP) begin
      m0_icb_cmd_ready = s_icb_cmd_ready & ~cmd_own_s;
      m1_icb_cmd_ready = s_icb_cmd_ready &  cmd_own_s;
    end else begin
      m0_icb_cmd_ready = 1'b0;
    end
  end

  assign cmd_hs_s        = s_icb_cmd_valid & s_icb_cmd_ready;
  assign own_rsp_ready_s = own_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;
  assign wd_hit_s        = (TO_CYC != 0) && (cnt_q == TO_LAST);

  // Next-state, watchdog and response selection
  always_comb begin
    state_d         = state_q;
    own_d           = own_q;
    to_d            = to_q;
    cnt_d           = cnt_q;
    rsp_valid_s     = 1'b0;
    rsp_err_s       = 1'b0;
    rsp_rdata_s     = '0;
    rsp_done_s      = 1'b0;
    s_icb_rsp_ready = 1'b0;
    timeout_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // a late slave response after a timeout or reset is swallowed here
        s_icb_rsp_ready = 1'b1;
        if (any_valid_s) begin
          own_d   = sel_s;
          state_d = cmd_hs_s ? ST_RSP : ST_CMD;
          cnt_d   = '0;
          to_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (cmd_hs_s) begin
          state_d = ST_RSP;
          cnt_d   = '0;
          to_d    = 1'b0;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_RSP: begin
        if (to_q) begin
          // hold the error response; drain anything the slave sends meanwhile
          rsp_valid_s     = 1'b1;
          rsp_err_s       = 1'b1;
          s_icb_rsp_ready = 1'b1;
          rsp_done_s      = own_rsp_ready_s;
        end else if (s_icb_rsp_valid) begin
          // slave response beats a coincident timeout
          rsp_valid_s     = 1'b1;
          rsp_err_s       = s_icb_rsp_err;
          rsp_rdata_s     = s_icb_rsp_rdata;
          s_icb_rsp_ready = own_rsp_ready_s;
          rsp_done_s      = own_rsp_ready_s;
          if (!own_rsp_ready_s && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + CW'(1'b1);
          end else begin
            cnt_d = cnt_q;
          end
        end else if (wd_hit_s) begin
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          timeout_o   = 1'b1;
          to_d        = 1'b1;
          rsp_done_s  = own_rsp_ready_s;
        end else if (cnt_q != TO_LAST) begin
          cnt_d = cnt_q + CW'(1'b1);
        end else begin
          cnt_d = cnt_q;
        end
        if (rsp_done_s) begin
          state_d = ST_IDLE;
          to_d    = 1'b0;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        own_d   = 1'b0;
        to_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef ICB_ARB_RR_EN
  // Pointer hands preference to the non-owner once a response completes
  always_comb begin
    if ((state_q == ST_RSP) && rsp_done_s) begin
      ptr_d = ~own_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Response demux: the non-owner never sees a response
  always_comb begin
    m0_icb_rsp_valid = rsp_valid_s & ~own_q;
    m0_icb_rsp_err   = rsp_err_s   & ~own_q;
    m0_icb_rsp_rdata = own_q ? '0 : rsp_rdata_s;
    m1_icb_rsp_valid = rsp_valid_s &  own_q;
    m1_icb_rsp_err   = rsp_err_s   &  own_q;
    m1_icb_rsp_rdata = own_q ? rsp_rdata_s : '0;
  end

  // FSM, ownership and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      own_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
